dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 159 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port data memory arbiter with a port-1 exclusive lock.
// Port 0 is the core data port and port 1 is the debug/loader port. Grants are
// combinational. Contention is resolved round-robin, and port 1 can lock out
// port 0. Reads return data one cycle after the grant on the issuing port.
// Optional feature: define DMEM_ARB_PERF_EN to add 32-bit performance counters
// (perf_gnt0, perf_gnt1, perf_conflict).
module dmem_arbiter #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_op,
    input  logic [31:0]       p0_addr,
    input  logic [3:0]        p0_mask,
    input  logic [31:0]       p0_wdata,
    input  logic              p1_req,
    input  logic              p1_op,
    input  logic [31:0]       p1_addr,
    input  logic [3:0]        p1_mask,
    input  logic [31:0]       p1_wdata,
    input  logic              p1_lock,
    output logic              p0_gnt,
    output logic              p1_gnt,
    output logic              p0_rvalid,
    output logic              p1_rvalid,
    output logic [31:0]       p0_rdata,
    output logic [31:0]       p1_rdata,
    output logic              mem_en,
    output logic              mem_op,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_mask,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_gnt0,
    output logic [31:0]       perf_gnt1,
    output logic [31:0]       perf_conflict
`endif
);

    typedef enum logic {
        OPEN   = 1'b0,
        LOCKED = 1'b1
    } lock_state_t;

    lock_state_t lock_state;
    lock_state_t lock_next;

    // last_gnt = 1 means port 1 was granted most recently, so port 0 wins the next tie
    logic last_gnt;
    logic rd_pend;
    logic rd_port;

    // Byte-offset and high address bits never reach the word-addressed memory
    logic unused_addr_bits;
    assign unused_addr_bits = ^{p0_addr[31:ADDR_W+2], p0_addr[1:0],
                                p1_addr[31:ADDR_W+2], p1_addr[1:0]};

    // Lock state, round-robin history and pending-read tag; rst is active-low
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_state <= OPEN;
            last_gnt   <= 1'b1;
            rd_pend    <= 1'b0;
            rd_port    <= 1'b0;
        end else begin
            lock_state <= lock_next;
            rd_pend    <= mem_en && !mem_op;
            if (mem_en) begin
                last_gnt <= p1_gnt;
                rd_port  <= p1_gnt;
            end
        end
    end

    // Grant selection and lock next-state; nothing is granted while in reset
    always_comb begin
        p0_gnt    = 1'b0;
        p1_gnt    = 1'b0;
        lock_next = lock_state;
        if (rst) begin
            case (lock_state)
                OPEN: begin
                    if (p0_req && p1_req) begin
                        p0_gnt = last_gnt;
                        p1_gnt = !last_gnt;
                    end else begin
                        p0_gnt = p0_req;
                        p1_gnt = p1_req;
                    end
                    if (p1_gnt && p1_lock) begin
                        lock_next = LOCKED;
                    end
                end
                LOCKED: begin
                    p1_gnt = p1_req;
                    if (!p1_lock) begin
                        lock_next = OPEN;
                    end
                end
                default: lock_next = OPEN;
            endcase
        end
    end

    // Memory request mux; all fields are zero when no port is granted
    always_comb begin
        mem_en    = p0_gnt | p1_gnt;
        mem_op    = 1'b0;
        mem_addr  = '0;
        mem_mask  = 4'h0;
        mem_wdata = 32'h0;
        if (p1_gnt) begin
            mem_op    = p1_op;
            mem_addr  = p1_addr[ADDR_W+1:2];
            mem_mask  = p1_op ? p1_mask : 4'h0;
            mem_wdata = p1_wdata;
        end else if (p0_gnt) begin
            mem_op    = p0_op;
            mem_addr  = p0_addr[ADDR_W+1:2];
            mem_mask  = p0_op ? p0_mask : 4'h0;
            mem_wdata = p0_wdata;
        end
    end

    // Read response steering back to the port that issued the read
    always_comb begin
        p0_rvalid = rd_pend && !rd_port;
        p1_rvalid = rd_pend && rd_port;
        p0_rdata  = p0_rvalid ? mem_rdata : 32'h0;
        p1_rdata  = p1_rvalid ? mem_rdata : 32'h0;
    end

`ifdef DMEM_ARB_PERF_EN
    logic [31:0] cnt_gnt0;
    logic [31:0] cnt_gnt1;
    logic [31:0] cnt_conflict;

    // Free-running wrap-around counters of grants and contended cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_gnt0     <= 32'h0;
            cnt_gnt1     <= 32'h0;
            cnt_conflict <= 32'h0;
        end else begin
            cnt_gnt0     <= cnt_gnt0 + {31'h0, p0_gnt};
            cnt_gnt1     <= cnt_gnt1 + {31'h0, p1_gnt};
            cnt_conflict <= cnt_conflict + {31'h0, p0_req & p1_req};
        end
    end

    assign perf_gnt0     = cnt_gnt0;
    assign perf_gnt1     = cnt_gnt1;
    assign perf_conflict = cnt_conflict;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and randomized bench for dmem_arbiter with a
// behavioural memory, a transaction-level model and a per-cycle comparison.
// Counter checks are compiled in only when DMEM_ARB_PERF_EN is defined.
module tb_dmem_arbiter;

    localparam int ADDR_W = 14;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              p0_req, p0_op, p1_req, p1_op, p1_lock;
    logic [31:0]       p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic [3:0]        p0_mask, p1_mask;
    logic              p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [31:0]       p0_rdata, p1_rdata;
    logic              mem_en, mem_op;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_mask;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata = 32'h0;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0]       perf_gnt0, perf_gnt1, perf_conflict;
`endif

    int checks   = 0;
    int failures = 0;

    logic [31:0] env_mem   [DEPTH];
    logic [31:0] model_mem [DEPTH];

    dmem_arbiter #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_op(p0_op), .p0_addr(p0_addr), .p0_mask(p0_mask), .p0_wdata(p0_wdata),
        .p1_req(p1_req), .p1_op(p1_op), .p1_addr(p1_addr), .p1_mask(p1_mask), .p1_wdata(p1_wdata),
        .p1_lock(p1_lock),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
        .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .mem_en(mem_en), .mem_op(mem_op), .mem_addr(mem_addr), .mem_mask(mem_mask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        , .perf_gnt0(perf_gnt0), .perf_gnt1(perf_gnt1), .perf_conflict(perf_conflict)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return 32'h5A000000 | 32'(i);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory environment: one-cycle read latency, byte-masked writes
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_op) env_mem[mem_addr] <= merge(env_mem[mem_addr], mem_wdata, mem_mask);
            else        mem_rdata <= env_mem[mem_addr];
        end
    end

    // Transaction-level model state
    int          m_last;
    bit          m_locked;
    bit          m_pend;
    int          m_pend_port;
    logic [31:0] m_pend_data;
    int          win;
    logic        w_op;
    logic [31:0] w_addr, w_wdata, e_addr;
    logic [3:0]  w_mask;
    int          w_idx;

    // Per-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (!rst) begin
            check_output("rst_p0_gnt", 32'(p0_gnt), 0);
            check_output("rst_p1_gnt", 32'(p1_gnt), 0);
            check_output("rst_mem_en", 32'(mem_en), 0);
            check_output("rst_mem_fields", {mem_op, mem_mask, 27'(mem_addr)}, 0);
            check_output("rst_mem_wdata", mem_wdata, 0);
            check_output("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
            check_output("rst_p0_rdata", p0_rdata, 0);
            check_output("rst_p1_rdata", p1_rdata, 0);
            m_last   = 1;
            m_locked = 0;
            m_pend   = 0;
        end else begin
            check_output("m_p0_rvalid", 32'(p0_rvalid), 32'(m_pend && m_pend_port == 0));
            check_output("m_p1_rvalid", 32'(p1_rvalid), 32'(m_pend && m_pend_port == 1));
            check_output("m_p0_rdata", p0_rdata, (m_pend && m_pend_port == 0) ? m_pend_data : 32'h0);
            check_output("m_p1_rdata", p1_rdata, (m_pend && m_pend_port == 1) ? m_pend_data : 32'h0);
            win = -1;
            if (m_locked)               begin if (p1_req) win = 1; end
            else if (p0_req && p1_req)  win = (m_last == 1) ? 0 : 1;
            else if (p0_req)            win = 0;
            else if (p1_req)            win = 1;
            check_output("m_p0_gnt", 32'(p0_gnt), 32'(win == 0));
            check_output("m_p1_gnt", 32'(p1_gnt), 32'(win == 1));
            check_output("m_mem_en", 32'(mem_en), 32'(win >= 0));
            m_pend = 0;
            if (win >= 0) begin
                w_op    = (win == 1) ? p1_op    : p0_op;
                w_addr  = (win == 1) ? p1_addr  : p0_addr;
                w_mask  = (win == 1) ? p1_mask  : p0_mask;
                w_wdata = (win == 1) ? p1_wdata : p0_wdata;
                w_idx   = int'(w_addr / 4) % DEPTH;
                e_addr  = 32'(w_idx);
                check_output("m_mem_op", 32'(mem_op), 32'(w_op));
                check_output("m_mem_addr", 32'(mem_addr), e_addr);
                check_output("m_mem_mask", 32'(mem_mask), w_op ? 32'(w_mask) : 32'h0);
                check_output("m_mem_wdata", mem_wdata, w_wdata);
                m_last = win;
                if (w_op) begin
                    model_mem[w_idx] = merge(model_mem[w_idx], w_wdata, w_mask);
                end else begin
                    m_pend      = 1;
                    m_pend_port = win;
                    m_pend_data = model_mem[w_idx];
                end
            end
            if (!m_locked && win == 1 && p1_lock) m_locked = 1;
            else if (m_locked && !p1_lock)        m_locked = 0;
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_stimulus(input int port, input logic req, input logic op,
                                  input logic [31:0] addr, input logic [3:0] mask,
                                  input logic [31:0] wdata, input logic lock);
        if (port == 0) begin
            p0_req = req; p0_op = op; p0_addr = addr; p0_mask = mask; p0_wdata = wdata;
        end else begin
            p1_req = req; p1_op = op; p1_addr = addr; p1_mask = mask; p1_wdata = wdata;
            p1_lock = lock;
        end
    endtask

    task automatic idle_ports();
        apply_stimulus(0, 0, 0, 32'h0, 4'h0, 32'h0, 0);
        apply_stimulus(1, 0, 0, 32'h0, 4'h0, 32'h0, 0);
    endtask

    task automatic random_port(input int port);
        logic [31:0] a;
        a = {$urandom_range(0, 16'hFFFF), 16'h0} | (32'($urandom_range(0, 63)) << 2)
            | 32'($urandom_range(0, 3));
        apply_stimulus(port, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a,
                       4'($urandom_range(0, 15)), $urandom, (port == 1) ? p1_lock : 1'b0);
    endtask

    logic g0, g1;

    initial begin
        rst = 1'b0;
        idle_ports();
        for (int i = 0; i < DEPTH; i++) begin
            env_mem[i]   = init_word(i);
            model_mem[i] = init_word(i);
        end
        env_mem[16'h400]   = 32'hdeadbeef;
        model_mem[16'h400] = 32'hdeadbeef;

        // Requests during reset are ignored
        p0_req = 1'b1;
        p1_req = 1'b1;
        @(negedge clk);
        check_output("reset_p0_gnt", 32'(p0_gnt), 0);
        check_output("reset_p1_gnt", 32'(p1_gnt), 0);
        check_output("reset_mem_en", 32'(mem_en), 0);
        next_cycle();
        idle_ports();
        rst = 1'b1;

        // Lone p0 read of byte address 0x1000
        next_cycle();
        apply_stimulus(0, 1, 0, 32'h1000, 4'hF, 32'h0, 0);
        @(negedge clk);
        check_output("rd_p0_gnt", 32'(p0_gnt), 1);
        check_output("rd_mem_addr", 32'(mem_addr), 32'h400);
        check_output("rd_mem_mask", 32'(mem_mask), 0);
        next_cycle();
        idle_ports();
        @(negedge clk);
        check_output("rd_p0_rvalid", 32'(p0_rvalid), 1);
        check_output("rd_p0_rdata", p0_rdata, 32'hdeadbeef);
        check_output("rd_p1_rvalid", 32'(p1_rvalid), 0);
        next_cycle();
        @(negedge clk);
        check_output("rd_p0_rvalid_once", 32'(p0_rvalid), 0);

        // Continuous contention after reset alternates p0, p1, p0, p1
        rst = 1'b0;
        next_cycle();
        rst = 1'b1;
        for (int k = 0; k < 4; k++) begin
            next_cycle();
            apply_stimulus(0, 1, 0, 32'h200, 4'h0, 32'h0, 0);
            apply_stimulus(1, 1, 0, 32'h300, 4'h0, 32'h0, 0);
            @(negedge clk);
            check_output($sformatf("rr_p0_gnt_%0d", k), 32'(p0_gnt), 32'(k % 2 == 0));
            check_output($sformatf("rr_p1_gnt_%0d", k), 32'(p1_gnt), 32'(k % 2 == 1));
        end
        next_cycle();
        idle_ports();
        @(negedge clk);
        check_output("rr_p1_rdata", p1_rdata, 32'h5A0000C0);
`ifdef DMEM_ARB_PERF_EN
        check_output("rr_perf_conflict", perf_conflict, 4);
        check_output("rr_perf_gnt1", perf_gnt1, 2);
`endif

        // p0 granted last, so p1 wins the tie and then holds the lock
        next_cycle();
        apply_stimulus(0, 1, 1, 32'h0, 4'hF, 32'h11111111, 0);
        @(negedge clk);
        check_output("lk_pre_p0_gnt", 32'(p0_gnt), 1);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            apply_stimulus(0, 1, 0, 32'h104, 4'h0, 32'h0, 0);
            apply_stimulus(1, 1, 1, 32'h100, 4'hF, 32'h12345678, 1);
            @(negedge clk);
            check_output($sformatf("lk_p0_gnt_%0d", k), 32'(p0_gnt), 0);
            check_output($sformatf("lk_p1_gnt_%0d", k), 32'(p1_gnt), 1);
        end
        next_cycle();
        apply_stimulus(1, 0, 0, 32'h0, 4'h0, 32'h0, 0);
        @(negedge clk);
        check_output("lk_drop_p0_gnt", 32'(p0_gnt), 0);
        next_cycle();
        @(negedge clk);
        check_output("lk_after_p0_gnt", 32'(p0_gnt), 1);
        next_cycle();
        idle_ports();
        @(negedge clk);
        check_output("lk_p0_rdata", p0_rdata, 32'h5A000041);

        // Read by p0 followed immediately by a write from p1
        next_cycle();
        apply_stimulus(0, 1, 0, 32'h100, 4'h0, 32'h0, 0);
        next_cycle();
        idle_ports();
        apply_stimulus(1, 1, 1, 32'h200, 4'h1, 32'hFF, 0);
        @(negedge clk);
        check_output("b2b_p1_gnt", 32'(p1_gnt), 1);
        check_output("b2b_p0_rvalid", 32'(p0_rvalid), 1);
        check_output("b2b_p0_rdata", p0_rdata, 32'h12345678);

        // Single-byte write through port 1
        next_cycle();
        apply_stimulus(1, 1, 1, 32'h101, 4'h2, 32'h00007800, 0);
        @(negedge clk);
        check_output("sb_mem_addr", 32'(mem_addr), 32'h40);
        check_output("sb_mem_mask", 32'(mem_mask), 32'h2);
        check_output("sb_mem_wdata", mem_wdata, 32'h00007800);
        next_cycle();
        idle_ports();
        @(negedge clk);
        check_output("sb_no_rvalid", {p0_rvalid, p1_rvalid}, 0);

        // Reset right after a read grant cancels the response
        next_cycle();
        apply_stimulus(0, 1, 0, 32'h100, 4'h0, 32'h0, 0);
        next_cycle();
        idle_ports();
        rst = 1'b0;
        @(negedge clk);
        check_output("rr_cancel_rvalid", 32'(p0_rvalid), 0);
        check_output("rr_cancel_rdata", p0_rdata, 0);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        check_output("rr_release_rvalid", 32'(p0_rvalid), 0);
        next_cycle();
        apply_stimulus(0, 1, 0, 32'h100, 4'h0, 32'h0, 0);
        apply_stimulus(1, 1, 0, 32'h104, 4'h0, 32'h0, 0);
        @(negedge clk);
        check_output("rr_first_p0_gnt", 32'(p0_gnt), 1);
        check_output("rr_first_p1_gnt", 32'(p1_gnt), 0);
        next_cycle();
        apply_stimulus(0, 0, 0, 32'h0, 4'h0, 32'h0, 0);
        @(negedge clk);
        check_output("rr_second_p1_gnt", 32'(p1_gnt), 1);
        check_output("rr_merged_rdata", p0_rdata, 32'h12347878);
        next_cycle();
        idle_ports();

`ifdef DMEM_ARB_PERF_EN
        // Grant counter wraps from all-ones to zero
        next_cycle();
        force dut.cnt_gnt0 = 32'hFFFFFFFF;
        #1;
        release dut.cnt_gnt0;
        apply_stimulus(0, 1, 0, 32'h0, 4'h0, 32'h0, 0);
        @(negedge clk);
        check_output("perf_preload", perf_gnt0, 32'hFFFFFFFF);
        next_cycle();
        idle_ports();
        @(negedge clk);
        check_output("perf_wrap", perf_gnt0, 32'h0);
`endif

        // Randomized traffic with lock toggles and occasional resets
        for (int n = 0; n < 4000; n++) begin
            @(negedge clk);
            g0 = p0_gnt;
            g1 = p1_gnt;
            next_cycle();
            if (!rst) rst = 1'b1;
            else if ($urandom_range(0, 199) == 0) rst = 1'b0;
            if ($urandom_range(0, 7) == 0) p1_lock = ~p1_lock;
            if (!p0_req || g0) random_port(0);
            if (!p1_req || g1) random_port(1);
        end
        next_cycle();
        rst = 1'b1;
        idle_ports();
        repeat (3) next_cycle();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
